// File: rtl/p2s_dac_if.sv
// Sample-input handshake bundle for p2s_dac.
//   s_left / s_right : stereo sample pair, two's complement, DATA_W bits each
//   s_valid          : producer offers a pair
//   s_ready          : consumer can take a pair
// Handshake: a pair moves on a posedge where s_valid & s_ready are both 1.
// The producer keeps the pair and s_valid stable until that happens.
// s_ready does not depend on s_valid.
interface p2s_dac_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] s_left;
  logic [DATA_W-1:0] s_right;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_left, output s_right, output s_valid, input s_ready);
  modport slave  (input s_left, input s_right, input s_valid, output s_ready);
endinterface

// File: rtl/p2s_dac.sv
// Parallel-to-serial transmitter for the codec DAC (playback) path.
// Stereo pairs are buffered in a small FIFO. Each sample is shifted out
// MSB-first on dacdat. The frame is set by the codec-driven daclrc
// (1 = left half, 0 = right half).
// Ports:
//   clk        bit clock; all logic runs on posedge
//   rst_n      synchronous reset, active-low
//   daclrc     frame clock from the codec
//   s          sample handshake (p2s_dac_if slave: s_left, s_right, s_valid, s_ready)
//   dacdat     registered serial data to the codec
//   underrun   one-cycle pulse when a frame starts with the FIFO empty
//   fifo_level number of stereo entries currently held
//   state_dbg  serialiser state (0 = IDLE, 1 = SHIFT)
module p2s_dac #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 2,
  parameter bit UNDERRUN_Z = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          daclrc,
  p2s_dac_if.slave                      s,
  output logic                          dacdat,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          state_dbg
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t              state;
  logic [DATA_W-1:0]   mem_l [FIFO_DEPTH];
  logic [DATA_W-1:0]   mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic                ready_en;
  logic                daclrc_d;
  logic [DATA_W-1:0]   tx_l;
  logic [DATA_W-1:0]   tx_r;
  logic [DATA_W-1:0]   last_l;
  logic [DATA_W-1:0]   last_r;
  logic                sel_r;
  logic [CNT_W-1:0]    bitcnt;

  logic                rise;
  logic                fall;
  logic                push;
  logic                pop;
  logic [DATA_W-1:0]   head_l;
  logic [DATA_W-1:0]   head_r;
  logic [DATA_W-1:0]   new_l;
  logic [DATA_W-1:0]   new_r;
  logic [DATA_W-1:0]   cur_word;

  assign rise = daclrc & ~daclrc_d;
  assign fall = ~daclrc & daclrc_d;

  // ready_en stays low during reset, so s_ready is 0 while rst_n is asserted
  // and rises one cycle after release.
  assign s.s_ready = ready_en & (fifo_level < LVL_W'(FIFO_DEPTH));
  assign push      = s.s_valid & s.s_ready;
  // Pop only on a left-half start. There is no bypass, so a pair pushed in
  // the same cycle as a rise on an empty FIFO waits for the next frame.
  assign pop       = rise & (fifo_level != '0);

  assign head_l   = mem_l[rd_ptr];
  assign head_r   = mem_r[rd_ptr];
  assign new_l    = pop ? head_l : (UNDERRUN_Z ? '0 : last_l);
  assign new_r    = pop ? head_r : (UNDERRUN_Z ? '0 : last_r);
  assign cur_word = sel_r ? tx_r : tx_l;

  assign state_dbg = state;

  // Storage is left unreset; the pointers and the level define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_l[wr_ptr] <= s.s_left;
      mem_r[wr_ptr] <= s.s_right;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // daclrc_d follows daclrc even in reset, so release never looks like an edge.
      daclrc_d   <= daclrc;
      dacdat     <= 1'b0;
      underrun   <= 1'b0;
      fifo_level <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ready_en   <= 1'b0;
      state      <= IDLE;
      bitcnt     <= '0;
      sel_r      <= 1'b0;
      tx_l       <= '0;
      tx_r       <= '0;
      last_l     <= '0;
      last_r     <= '0;
    end else begin
      daclrc_d   <= daclrc;
      ready_en   <= 1'b1;
      underrun   <= rise & ~pop;
      fifo_level <= fifo_level + LVL_W'(push) - LVL_W'(pop);
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      // An edge always wins over the shift in progress. This truncates short
      // half-frames, and the new channel starts its MSB in the same cycle.
      if (rise) begin
        tx_l   <= new_l;
        tx_r   <= new_r;
        if (pop) begin
          last_l <= head_l;
          last_r <= head_r;
        end
        dacdat <= new_l[DATA_W-1];
        bitcnt <= CNT_W'(DATA_W - 2);
        sel_r  <= 1'b0;
        state  <= SHIFT;
      end else if (fall) begin
        dacdat <= tx_r[DATA_W-1];
        bitcnt <= CNT_W'(DATA_W - 2);
        sel_r  <= 1'b1;
        state  <= SHIFT;
      end else begin
        case (state)
          SHIFT: begin
            dacdat <= cur_word[bitcnt];
            if (bitcnt == '0) state  <= IDLE;
            else              bitcnt <= bitcnt - CNT_W'(1);
          end
          default: begin
            // Zero padding for frames longer than DATA_W bits.
            dacdat <= 1'b0;
            state  <= IDLE;
          end
        endcase
      end
    end
  end
endmodule
